// File: rtl/div_arb_2p.sv
`default_nettype none
// ============================================================================
// Module   : div_arb_2p
// Purpose  : Two-port round-robin front end for a single shared 8-bit divider.
//            Grants one requester at a time, latches its operands, starts the
//            divider (or short-circuits a zero divisor), waits for completion
//            with a timeout, and returns the result with a done pulse to the
//            owner of the operation.
// Ports    : clk, reset (async, active-low)
//            req0/req1, a0/b0/a1/b1        - requester side
//            gnt0/gnt1, done0/done1        - handshake pulses
//            quo_o, resto_o, zero_o, erro_o - result of last operation
//            busy                          - high outside IDLE
//            d_start, d_div1, d_div2       - divider command side
//            d_quo, d_resto, d_fim, d_zero_div - divider response side
// Revision : 1.0 - initial release
// ============================================================================
module div_arb_2p #(
    parameter int TIMEOUT = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] quo_o,
    output logic [7:0] resto_o,
    output logic       zero_o,
    output logic       erro_o,
    output logic       busy,
    output logic       d_start,
    output logic [7:0] d_div1,
    output logic [7:0] d_div2,
    input  logic [7:0] d_quo,
    input  logic [7:0] d_resto,
    input  logic       d_fim,
    input  logic       d_zero_div
);

    // Counter value of the last WAIT cycle allowed before the abort.
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_ptr;
    logic       r_owner;
    logic [7:0] r_cnt;
    logic [7:0] r_div1;
    logic [7:0] r_div2;
    logic [7:0] r_quo;
    logic [7:0] r_resto;
    logic       r_zero;
    logic       r_erro;

    logic       w_any_req;
    logic       w_winner;
    logic       w_div_zero;
    logic       w_fim_ok;
    logic       w_timeout;

    assign w_any_req  = req0 | req1;
    // Contention goes to the pointer; a lone requester wins regardless.
    assign w_winner   = (req0 & req1) ? r_ptr : req1;
    assign w_div_zero = (r_div2 == 8'd0);
    // The first WAIT cycle (counter still 0) may see d_fim left over from the
    // previous operation, so completion is only trusted from the second on.
    assign w_fim_ok   = d_fim && (r_cnt != 8'd0);
    assign w_timeout  = (r_cnt == c_wait_last);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_START;
            S_START: w_state_nxt = w_div_zero ? S_RESP : S_WAIT;
            S_WAIT:  if (w_fim_ok || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_cnt   <= 8'd0;
            r_div1  <= 8'd0;
            r_div2  <= 8'd0;
            r_quo   <= 8'd0;
            r_resto <= 8'd0;
            r_zero  <= 1'b0;
            r_erro  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_winner;
                        r_div1  <= w_winner ? a1 : a0;
                        r_div2  <= w_winner ? b1 : b0;
                    end
                end
                S_START: begin
                    r_cnt <= 8'd0;
                    if (w_div_zero) begin
                        r_quo   <= 8'hFF;
                        r_resto <= r_div1;
                        r_zero  <= 1'b1;
                        r_erro  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // Completion takes precedence over a coincident timeout.
                    if (w_fim_ok) begin
                        r_quo   <= d_quo;
                        r_resto <= d_resto;
                        r_zero  <= d_zero_div;
                        r_erro  <= 1'b0;
                    end else if (w_timeout) begin
                        r_quo   <= 8'd0;
                        r_resto <= 8'd0;
                        r_zero  <= 1'b0;
                        r_erro  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_ptr <= ~r_ptr;
                end
                default: ;
            endcase
        end
    end

    assign gnt0    = (r_state == S_START) && !r_owner;
    assign gnt1    = (r_state == S_START) &&  r_owner;
    assign done0   = (r_state == S_RESP)  && !r_owner;
    assign done1   = (r_state == S_RESP)  &&  r_owner;
    assign d_start = (r_state == S_START) && !w_div_zero;
    assign busy    = (r_state != S_IDLE);
    assign d_div1  = r_div1;
    assign d_div2  = r_div2;
    assign quo_o   = r_quo;
    assign resto_o = r_resto;
    assign zero_o  = r_zero;
    assign erro_o  = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_div_arb_2p.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_arb_2p
// Purpose  : Directed self-checking bench for div_arb_2p with a behavioural
//            divider (fim 10 cycles after start, held until the cycle after
//            the next start is seen).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_arb_2p;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] a0 = 8'd0, b0 = 8'd0, a1 = 8'd0, b1 = 8'd0;
    logic       gnt0, gnt1, done0, done1, zero_o, erro_o, busy, d_start;
    logic [7:0] quo_o, resto_o, d_div1, d_div2;
    logic [7:0] d_quo = 8'd0, d_resto = 8'd0;
    logic       d_fim = 1'b0, d_zero_div = 1'b0;

    div_arb_2p #(.TIMEOUT(31)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .quo_o(quo_o), .resto_o(resto_o), .zero_o(zero_o), .erro_o(erro_o),
        .busy(busy), .d_start(d_start), .d_div1(d_div1), .d_div2(d_div2),
        .d_quo(d_quo), .d_resto(d_resto), .d_fim(d_fim), .d_zero_div(d_zero_div)
    );

    always #5 clk = ~clk;

    // Divider model
    logic [7:0] m_a = 8'd0, m_b = 8'd1;
    int         m_cnt = 0;
    bit         m_clr = 1'b0;
    bit         fim_en = 1'b1;

    always @(posedge clk) begin
        if (d_start) begin
            m_a   <= d_div1;
            m_b   <= d_div2;
            m_cnt <= 9;
            m_clr <= 1'b1;
        end else begin
            if (m_clr) begin
                d_fim <= 1'b0;
                m_clr <= 1'b0;
            end
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1 && fim_en && m_b != 8'd0) begin
                    d_fim   <= 1'b1;
                    d_quo   <= m_a / m_b;
                    d_resto <= m_a % m_b;
                end
            end
        end
    end

    int         nvec = 0, nerr = 0;
    int         cyc = 0;
    int         n_g0, n_g1, n_d0, n_d1, n_st, gnt_cyc, done_cyc, first_gnt;
    logic [7:0] st_d1, st_d2;
    logic [7:0] rq[$];
    logic [7:0] rr[$];
    int         dord[$];

    task automatic clr_stats();
        n_g0 = 0; n_g1 = 0; n_d0 = 0; n_d1 = 0; n_st = 0;
        gnt_cyc = -1; done_cyc = -1; first_gnt = -1;
        st_d1 = 8'd0; st_d2 = 8'd0;
        rq.delete(); rr.delete(); dord.delete();
    endtask

    // Advance one cycle, observe at the falling edge, drop req on its grant.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (gnt0) begin n_g0++; if (first_gnt < 0) first_gnt = 0; gnt_cyc = cyc; req0 = 1'b0; end
        if (gnt1) begin n_g1++; if (first_gnt < 0) first_gnt = 1; gnt_cyc = cyc; req1 = 1'b0; end
        if (d_start) begin n_st++; st_d1 = d_div1; st_d2 = d_div2; end
        if (done0 || done1) begin
            done_cyc = cyc;
            rq.push_back(quo_o);
            rr.push_back(resto_o);
            dord.push_back(done1 ? 1 : 0);
            if (done0) n_d0++;
            if (done1) n_d1++;
        end
    endtask

    task automatic run_until(input int target, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (n_d0 + n_d1 >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        nvec++; if ({gnt0, gnt1, done0, done1, d_start, busy} !== 6'b0) begin
            nerr++; $display("FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, done0, done1, d_start, busy}); end
        nvec++; if ({zero_o, erro_o} !== 2'b0) begin
            nerr++; $display("FAIL reset_flags: got %b want 00", {zero_o, erro_o}); end
        nvec++; if ({quo_o, resto_o} !== 16'h0000) begin
            nerr++; $display("FAIL reset_result: got %h want 0000", {quo_o, resto_o}); end
        nvec++; if ({d_div1, d_div2} !== 16'h0000) begin
            nerr++; $display("FAIL reset_operands: got %h want 0000", {d_div1, d_div2}); end
        reset = 1'b1;
        tick(); tick();
        nvec++; if (busy !== 1'b0) begin
            nerr++; $display("FAIL idle_no_req: busy got %b want 0", busy); end
    endtask

    task automatic test_arbitration();
        bit ok;
        for (int round = 0; round < 2; round++) begin
            clr_stats();
            a0 = 8'd15; b0 = 8'd4; a1 = 8'd200; b1 = 8'd1;
            req0 = 1'b1; req1 = 1'b1;
            run_until(2, 80, ok);
            nvec++; if (ok !== 1'b1) begin
                nerr++; $display("FAIL arb_timeout: round %0d dones got %0d want 2", round, n_d0 + n_d1); end
            nvec++; if (first_gnt !== 0) begin
                nerr++; $display("FAIL arb_first: round %0d got %0d want 0", round, first_gnt); end
            nvec++; if ({n_g0, n_g1, n_d0, n_d1} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
                nerr++; $display("FAIL arb_pulses: g0 %0d g1 %0d d0 %0d d1 %0d want 1 each", n_g0, n_g1, n_d0, n_d1); end
            if (rq.size() == 2) begin
                nvec++; if ({rq[0], rr[0], rq[1], rr[1]} !== {8'd3, 8'd3, 8'd200, 8'd0}) begin
                    nerr++; $display("FAIL arb_results: got %0d/%0d %0d/%0d want 3/3 200/0", rq[0], rr[0], rq[1], rr[1]); end
            end
            tick();
        end
    endtask

    task automatic test_single();
        bit ok;
        int c0;
        clr_stats();
        tick();
        a0 = 8'd100; b0 = 8'd5; req0 = 1'b1;
        c0 = cyc;
        run_until(1, 40, ok);
        nvec++; if (ok !== 1'b1) begin
            nerr++; $display("FAIL single_timeout: done got %0d want 1", n_d0); end
        nvec++; if (gnt_cyc !== c0 + 1) begin
            nerr++; $display("FAIL single_gnt_lat: got %0d want %0d", gnt_cyc - c0, 1); end
        nvec++; if ({n_g0, n_g1, n_st, n_d0, n_d1} !== {32'd1, 32'd0, 32'd1, 32'd1, 32'd0}) begin
            nerr++; $display("FAIL single_pulses: g0 %0d g1 %0d st %0d d0 %0d d1 %0d want 1 0 1 1 0", n_g0, n_g1, n_st, n_d0, n_d1); end
        nvec++; if ({st_d1, st_d2} !== {8'd100, 8'd5}) begin
            nerr++; $display("FAIL single_operands: got %0d/%0d want 100/5", st_d1, st_d2); end
        nvec++; if (done_cyc - gnt_cyc !== 11) begin
            nerr++; $display("FAIL single_done_lat: got %0d want 11", done_cyc - gnt_cyc); end
        tick(); tick(); tick();
        nvec++; if ({quo_o, resto_o, zero_o, erro_o} !== {8'd20, 8'd0, 1'b0, 1'b0}) begin
            nerr++; $display("FAIL single_result_hold: got %0d/%0d z%b e%b want 20/0 z0 e0", quo_o, resto_o, zero_o, erro_o); end
    endtask

    task automatic test_rr_pointer();
        bit ok;
        clr_stats();
        a0 = 8'd15; b0 = 8'd4; a1 = 8'd200; b1 = 8'd1;
        req0 = 1'b1; req1 = 1'b1;
        run_until(2, 80, ok);
        nvec++; if (ok !== 1'b1) begin
            nerr++; $display("FAIL rr_timeout: dones got %0d want 2", n_d0 + n_d1); end
        nvec++; if (first_gnt !== 1) begin
            nerr++; $display("FAIL rr_first: got %0d want 1", first_gnt); end
        if (dord.size() == 2) begin
            nvec++; if ({dord[0], dord[1]} !== {32'd1, 32'd0}) begin
                nerr++; $display("FAIL rr_done_order: got %0d,%0d want 1,0", dord[0], dord[1]); end
        end
        tick();
    endtask

    task automatic test_zero_div();
        bit ok;
        clr_stats();
        a1 = 8'd50; b1 = 8'd0; req1 = 1'b1;
        run_until(1, 20, ok);
        nvec++; if (ok !== 1'b1) begin
            nerr++; $display("FAIL zero_timeout: done got %0d want 1", n_d1); end
        nvec++; if ({n_st, n_g1, n_d1} !== {32'd0, 32'd1, 32'd1}) begin
            nerr++; $display("FAIL zero_pulses: st %0d g1 %0d d1 %0d want 0 1 1", n_st, n_g1, n_d1); end
        nvec++; if (done_cyc - gnt_cyc !== 1) begin
            nerr++; $display("FAIL zero_lat: got %0d want 1", done_cyc - gnt_cyc); end
        nvec++; if ({quo_o, resto_o, zero_o, erro_o} !== {8'd255, 8'd50, 1'b1, 1'b0}) begin
            nerr++; $display("FAIL zero_result: got %0d/%0d z%b e%b want 255/50 z1 e0", quo_o, resto_o, zero_o, erro_o); end
        tick();
    endtask

    task automatic test_stale_fim();
        bit ok;
        clr_stats();
        a0 = 8'd77; b0 = 8'd9; req0 = 1'b1;
        run_until(1, 40, ok);
        nvec++; if (ok !== 1'b1) begin
            nerr++; $display("FAIL stale_timeout: done got %0d want 1", n_d0); end
        nvec++; if (done_cyc - gnt_cyc !== 11) begin
            nerr++; $display("FAIL stale_lat: got %0d want 11", done_cyc - gnt_cyc); end
        nvec++; if ({quo_o, resto_o, zero_o} !== {8'd8, 8'd5, 1'b0}) begin
            nerr++; $display("FAIL stale_result: got %0d/%0d z%b want 8/5 z0", quo_o, resto_o, zero_o); end
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        clr_stats();
        fim_en = 1'b0;
        a0 = 8'd9; b0 = 8'd3; req0 = 1'b1;
        run_until(1, 60, ok);
        nvec++; if (ok !== 1'b1) begin
            nerr++; $display("FAIL to_timeout: done got %0d want 1", n_d0); end
        nvec++; if (done_cyc - gnt_cyc !== 32) begin
            nerr++; $display("FAIL to_lat: got %0d want 32", done_cyc - gnt_cyc); end
        nvec++; if ({quo_o, resto_o, zero_o, erro_o} !== {8'd0, 8'd0, 1'b0, 1'b1}) begin
            nerr++; $display("FAIL to_result: got %0d/%0d z%b e%b want 0/0 z0 e1", quo_o, resto_o, zero_o, erro_o); end
        fim_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        clr_stats();
        a0 = 8'd100; b0 = 8'd7; req0 = 1'b1;
        for (int i = 0; i < 10 && n_g0 == 0; i++) tick();
        tick(); tick(); tick(); tick();
        #2 reset = 1'b0;
        #1;
        nvec++; if ({busy, done0, done1, d_start, erro_o, zero_o} !== 6'b0) begin
            nerr++; $display("FAIL mid_async_ctrl: got %b want 000000", {busy, done0, done1, d_start, erro_o, zero_o}); end
        nvec++; if ({quo_o, resto_o, d_div1, d_div2} !== 32'h0) begin
            nerr++; $display("FAIL mid_async_data: got %h want 00000000", {quo_o, resto_o, d_div1, d_div2}); end
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        nvec++; if (n_d0 + n_d1 !== 0) begin
            nerr++; $display("FAIL mid_no_done: got %0d want 0", n_d0 + n_d1); end
        a0 = 8'd100; b0 = 8'd7; req0 = 1'b1;
        run_until(1, 40, ok);
        nvec++; if ({ok, quo_o, resto_o, erro_o} !== {1'b1, 8'd14, 8'd2, 1'b0}) begin
            nerr++; $display("FAIL mid_after: ok%b got %0d/%0d e%b want ok1 14/2 e0", ok, quo_o, resto_o, erro_o); end
    endtask

    initial begin
        clr_stats();
        test_reset();
        test_arbitration();
        test_single();
        test_rr_pointer();
        test_zero_div();
        test_stale_fim();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
